instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Front end of the 3-stage RNBIP-2 pipeline. Fetches 16-bit instruction segments
//   ({opcode[15:8], operand[7:0]}) from program memory and delivers them in order,
//   with their next-PC, to the control generator stage.
//   Accepts the control stage's PC-load (L_PC) redirect, flushes buffered and
//   in-flight fetches, and resumes at the target.
// PARAMETERS
//   AW        8      program-memory word address width (PC width)
//   IW        16     instruction segment width
//   DEPTH     4      max (buffered + in-flight) fetches; power of 2, >= 2
//   RESET_PC  8'h00  first fetch address after reset
// PORTS
//   clk          in   1   clock, all state on rising edge
//   rst_n        in   1   synchronous active-low reset
//   pm_req       out  1   program-memory read request; memory always accepts
//   pm_addr      out  AW  word address of the request
//   pm_valid     in   1   read data valid; responses return in request order, latency >= 1
//   pm_rdata     in   IW  read data
//   redirect     in   1   L_PC from control stage: load fetch PC
//   redirect_pc  in   AW  branch/call/return target
//   seg_valid    out  1   segment/seg_npc hold a valid instruction
//   seg_ready    in   1   control stage consumes head this cycle
//   segment      out  IW  head instruction; 16'h0000 (NOP) when seg_valid=0
//   seg_npc      out  AW  head instruction address + 1 (mod 2^AW); 0 when seg_valid=0
// BEHAVIOUR
//   Reset (rst_n=0 at edge): fetch_pc<=RESET_PC, queue empty, inflight=0, drop_cnt=0,
//     state<=BOOT. Outputs during/after reset: pm_req=0, pm_addr=RESET_PC, seg_valid=0,
//     segment=0, seg_npc=0.
//   State machine:
//     BOOT  -> RUN unconditionally; no request issued in BOOT.
//     RUN   -> DRAIN on redirect when stale in-flight responses remain
//              (inflight minus any response returning that cycle > 0); otherwise stay in RUN.
//     DRAIN -> RUN when drop_cnt reaches 0. A redirect in DRAIN reloads drop_cnt.
//   Issue: pm_req = (state!=BOOT) & !redirect & (occ + inflight < DEPTH).
//     pm_req and pm_addr are derived from registers only, with redirect as the single gate.
//     Each issue: fetch_pc <= fetch_pc+1 (wraps FF->00) and inflight++.
//     Requests are issued in DRAIN too, from the new PC.
//   Response: each pm_valid does inflight--.
//     drop_cnt>0: data discarded, drop_cnt--.
//     drop_cnt=0: {pm_rdata, addr+1} is enqueued. The address comes from a parallel
//       in-order tag FIFO or a retire-PC counter.
//     pm_valid with inflight=0 is ignored.
//   Queue: registered FIFO of DEPTH entries; no bypass. Response at edge N gives seg_valid at N+1.
//     Overflow is impossible by the issue rule. Simultaneous enqueue+dequeue keeps occ.
//   Dequeue: seg_valid & seg_ready pops the head.
//   Redirect (highest priority): at the edge, queue cleared, fetch_pc<=redirect_pc,
//     drop_cnt <= inflight - (pm_valid?1:0).
//     A same-cycle pm_valid response is discarded.
//     A same-cycle pop is harmless; seg_valid=0 the next cycle.
//     First request to the target is issued the cycle after redirect.
//   Steady state with latency 1 and seg_ready=1: one segment per cycle.
//   Widths: occ, inflight, drop_cnt are $clog2(DEPTH)+1 bits and never exceed DEPTH.
// TESTING
//   1 Reset release, latency 1, pm[0]=16'h5903, pm[1]=16'h8802
//     -> pm_req first high 1 cycle after BOOT; seg_valid, segment=16'h5903, seg_npc=8'h01,
//     then 16'h8802/8'h02 on the following cycle.
//   2 seg_ready=0 for 10 cycles, latency 2
//     -> pm_req falls once occ+inflight=4; no pm_req while stalled;
//     segments from 00..03 are delivered in order after release, none lost or duplicated.
//   3 Latency 3, redirect to 8'h40 with 3 in flight -> state DRAIN, the 3 responses dropped;
//     next seg_valid shows pm[0x40], seg_npc=8'h41.
//   4 Redirect to 8'hFE -> segments pm[FE], pm[FF], pm[00] with seg_npc FF, 00, 01 (wrap).
//   5 Redirect in the same cycle as pm_valid and seg_ready -> that response dropped;
//     seg_valid=0 next cycle; no stale segment ever appears.
//   6 rst_n low for 1 cycle mid-DRAIN, then a late pm_valid -> ignored;
//     fetch restarts at RESET_PC with all outputs at reset values.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues in-order program-memory reads, buffers
// returned segments with their next-PC, and flushes/drains on a PC-load redirect.
//   state | meaning
//   BOOT  | first cycle after reset, no request issued
//   RUN   | normal fetch, responses enqueued
//   DRAIN | stale responses from before a redirect still returning; dropped
module instr_fetch_unit #(
  parameter int              AW       = 8,
  parameter int              IW       = 16,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          pm_req,
  output logic [AW-1:0] pm_addr,
  input  logic          pm_valid,
  input  logic [IW-1:0] pm_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          seg_valid,
  input  logic          seg_ready,
  output logic [IW-1:0] segment,
  output logic [AW-1:0] seg_npc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] retire_pc_q, retire_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] instr_q [DEPTH];
  logic [IW-1:0] instr_d [DEPTH];
  logic [AW-1:0] npc_q [DEPTH];
  logic [AW-1:0] npc_d [DEPTH];

  logic          resp;
  logic          pop;
  logic          enq;
  logic [CW:0]   budget;
  logic [CW-1:0] stale;

  assign budget    = {1'b0, occ_q} + {1'b0, inflight_q};
  assign pm_req    = (state_q != BOOT) && !redirect && (budget < DEPTH_W);
  assign pm_addr   = fetch_pc_q;
  assign seg_valid = (occ_q != '0);
  assign segment   = seg_valid ? instr_q[rd_ptr_q] : '0;
  assign seg_npc   = seg_valid ? npc_q[rd_ptr_q] : '0;

  // A response with nothing outstanding is spurious and ignored outright.
  assign resp  = pm_valid && (inflight_q != '0);
  assign pop   = seg_valid && seg_ready;
  assign enq   = resp && !redirect && (drop_cnt_q == '0);
  assign stale = inflight_q - CW'(resp);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    retire_pc_d = retire_pc_q;
    occ_d       = occ_q;
    drop_cnt_d  = drop_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    instr_d     = instr_q;
    npc_d       = npc_q;
    inflight_d  = inflight_q + CW'(pm_req) - CW'(resp);

    if (pm_req) fetch_pc_d = fetch_pc_q + AW'(1);

    if (redirect) begin
      fetch_pc_d  = redirect_pc;
      retire_pc_d = redirect_pc;
      occ_d       = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      drop_cnt_d  = stale;
      state_d     = (stale != '0) ? DRAIN : RUN;
    end else begin
      if (resp && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (enq) begin
        instr_d[wr_ptr_q] = pm_rdata;
        npc_d[wr_ptr_q]   = retire_pc_q + AW'(1);
        wr_ptr_d          = wr_ptr_q + PW'(1);
        retire_pc_d       = retire_pc_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      occ_d = occ_q + CW'(enq) - CW'(pop);
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = RUN;
        DRAIN:   if (drop_cnt_d == '0) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_PC;
      retire_pc_q <= RESET_PC;
      occ_q       <= '0;
      inflight_q  <= '0;
      drop_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        npc_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      retire_pc_q <= retire_pc_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      drop_cnt_q  <= drop_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      instr_q     <= instr_d;
      npc_q       <= npc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: program-memory responder with selectable
// latency and an in-order expected-address tracker for delivered segments.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pm_req;
  logic [7:0]  pm_addr;
  logic        pm_valid;
  logic [15:0] pm_rdata;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        seg_valid;
  logic        seg_ready;
  logic [15:0] segment;
  logic [7:0]  seg_npc;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pm_req     (pm_req),
    .pm_addr    (pm_addr),
    .pm_valid   (pm_valid),
    .pm_rdata   (pm_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .segment    (segment),
    .seg_npc    (seg_npc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] pm [256];
  int          cyc = 0;
  int          lat = 1;
  logic [7:0]  q_addr [$];
  int          q_due [$];
  logic [7:0]  exp_addr;
  int          delivered;
  int          reqs;

  // One clock cycle: present any due response, record the request the DUT
  // makes this cycle, and return at the next falling edge.
  task automatic tick();
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      pm_valid = 1'b1;
      pm_rdata = pm[q_addr[0]];
      void'(q_due.pop_front());
      void'(q_addr.pop_front());
    end else begin
      pm_valid = 1'b0;
      pm_rdata = '0;
    end
    #1;
    if (pm_req && rst_n) begin
      q_addr.push_back(pm_addr);
      q_due.push_back(cyc + lat);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect = 1'b0;
    seg_ready = 1'b0;
    tick();
    tick();
    q_addr.delete();
    q_due.delete();
    rst_n = 1'b1;
  endtask

  task automatic sb_run(input int n);
    logic [7:0] nx;
    for (int i = 0; i < n; i++) begin
      if (seg_valid) begin
        nx = exp_addr + 8'd1;
        chk_eq("seg_data", 32'(segment), 32'(pm[exp_addr]));
        chk_eq("seg_npc", 32'(seg_npc), 32'(nx));
        if (seg_ready) begin
          exp_addr = nx;
          delivered++;
        end
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a;
    for (int i = 0; i < 256; i++) begin
      a = i[7:0];
      pm[i] = {a ^ 8'h3C, a};
    end
    pm[0] = 16'h5903;
    pm[1] = 16'h8802;

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; seg_ready = 1'b0;
    pm_valid = 1'b0; pm_rdata = '0;
    @(negedge clk);
    tick();
    tick();
    chk_eq("rst_pm_req", 32'(pm_req), 32'd0);
    chk_eq("rst_pm_addr", 32'(pm_addr), 32'h00);
    chk_eq("rst_seg_valid", 32'(seg_valid), 32'd0);
    chk_eq("rst_segment", 32'(segment), 32'd0);
    chk_eq("rst_seg_npc", 32'(seg_npc), 32'd0);
    chk_eq("rst_state", 32'(dut.state_q), 32'd0);

    // 1: reset release, latency 1
    q_addr.delete(); q_due.delete();
    lat = 1; rst_n = 1'b1; seg_ready = 1'b1;
    chk_eq("t1_boot_noreq", 32'(pm_req), 32'd0);
    tick();
    chk_eq("t1_first_req", 32'(pm_req), 32'd1);
    chk_eq("t1_first_addr", 32'(pm_addr), 32'h00);
    chk_eq("t1_no_seg_yet", 32'(seg_valid), 32'd0);
    tick();
    chk_eq("t1_no_seg_yet2", 32'(seg_valid), 32'd0);
    chk_eq("t1_addr1", 32'(pm_addr), 32'h01);
    tick();
    chk_eq("t1_seg0_valid", 32'(seg_valid), 32'd1);
    chk_eq("t1_seg0", 32'(segment), 32'h5903);
    chk_eq("t1_npc0", 32'(seg_npc), 32'h01);
    tick();
    chk_eq("t1_seg1", 32'(segment), 32'h8802);
    chk_eq("t1_npc1", 32'(seg_npc), 32'h02);
    exp_addr = 8'h01; delivered = 0;
    sb_run(6);
    chk_eq("t1_throughput", 32'(delivered), 32'd6);

    // 2: stall with latency 2
    do_reset();
    lat = 2; seg_ready = 1'b0;
    tick();
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (pm_req) reqs++;
      tick();
    end
    chk_eq("t2_req_count", 32'(reqs), 32'd4);
    chk_eq("t2_req_low", 32'(pm_req), 32'd0);
    chk_eq("t2_head", 32'(segment), 32'(pm[0]));
    seg_ready = 1'b1;
    exp_addr = 8'h00; delivered = 0;
    sb_run(12);
    chk_eq("t2_drained", 32'(delivered >= 8), 32'd1);

    // 3: redirect with three in flight, latency 3
    do_reset();
    lat = 3; seg_ready = 1'b1;
    tick();
    tick(); tick(); tick();
    chk_eq("t3_inflight", 32'(dut.inflight_q), 32'd3);
    redirect = 1'b1; redirect_pc = 8'h40;
    tick();
    redirect = 1'b0;
    chk_eq("t3_state_drain", 32'(dut.state_q), 32'd2);
    chk_eq("t3_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    chk_eq("t3_flushed", 32'(seg_valid), 32'd0);
    exp_addr = 8'h40; delivered = 0;
    sb_run(14);
    chk_eq("t3_delivered", 32'(delivered >= 3), 32'd1);
    chk_eq("t3_state_run", 32'(dut.state_q), 32'd1);

    // 4: redirect near the top of the address space
    redirect = 1'b1; redirect_pc = 8'hFE;
    tick();
    redirect = 1'b0;
    exp_addr = 8'hFE; delivered = 0;
    sb_run(16);
    chk_eq("t4_wrap", 32'(delivered >= 4), 32'd1);

    // 5: redirect coinciding with a response and a pop
    do_reset();
    lat = 1; seg_ready = 1'b1;
    tick();
    tick(); tick(); tick();
    chk_eq("t5_pre_valid", 32'(seg_valid), 32'd1);
    redirect = 1'b1; redirect_pc = 8'h80;
    tick();
    redirect = 1'b0;
    chk_eq("t5_flushed", 32'(seg_valid), 32'd0);
    chk_eq("t5_state_run", 32'(dut.state_q), 32'd1);
    chk_eq("t5_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
    exp_addr = 8'h80; delivered = 0;
    sb_run(8);
    chk_eq("t5_delivered", 32'(delivered >= 5), 32'd1);

    // 6: reset during DRAIN, late response afterwards
    do_reset();
    lat = 3; seg_ready = 1'b1;
    tick();
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 8'h20;
    tick();
    redirect = 1'b0;
    chk_eq("t6_drain", 32'(dut.state_q), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_eq("t6_pm_req", 32'(pm_req), 32'd0);
    chk_eq("t6_pm_addr", 32'(pm_addr), 32'h00);
    chk_eq("t6_seg_valid", 32'(seg_valid), 32'd0);
    chk_eq("t6_segment", 32'(segment), 32'd0);
    chk_eq("t6_seg_npc", 32'(seg_npc), 32'd0);
    chk_eq("t6_state_boot", 32'(dut.state_q), 32'd0);
    chk_eq("t6_late_pending", 32'(q_due.size()), 32'd1);
    tick();
    chk_eq("t6_late_ignored", 32'(dut.inflight_q), 32'd0);
    chk_eq("t6_no_stale", 32'(seg_valid), 32'd0);
    exp_addr = 8'h00; delivered = 0;
    sb_run(12);
    chk_eq("t6_restart", 32'(delivered >= 3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
